reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   MIPS general-purpose register file: 2 asynchronous read ports, 1 synchronous write port.
//   It is the write-side endpoint of the datapath's select muxes:
//     - the write-register mux drives wa (rt / rd / $ra);
//     - the MemToReg mux drives wd.
//   Read ports feed the ALU operand path and the ALUSrc mux.
//   Register 0 is hard-wired to zero. An optional write-through bypass serves same-cycle readers.
// PARAMETERS
//   WIDTH     32  bit width of each register and of all data ports
//   ADDR_W    5   address width; register count = 2**ADDR_W
//   BYPASS    1   1 = a read of the address being written returns wd in the same cycle; 0 = returns old value
// PORTS
//   clk     in   1        rising-edge clock, sole clock domain
//   reset   in   1        synchronous, active-high; clears all registers
//   we      in   1        write enable (RegWrite)
//   wa      in   ADDR_W   write address
//   wd      in   WIDTH    write data
//   ra1     in   ADDR_W   read address port 1 (rs)
//   ra2     in   ADDR_W   read address port 2 (rt)
//   rd1     out  WIDTH    read data port 1
//   rd2     out  WIDTH    read data port 2
//   dbg_a   in   ADDR_W   debug read address (bench/trace only)
//   dbg_d   out  WIDTH    debug read data; never bypassed
//   wr_cnt  out  16       count of committed writes since reset, wraps 0xFFFF->0
// BEHAVIOUR
//   Storage
//     - Array of 2**ADDR_W entries x WIDTH, updated only on the rising edge of clk.
//   Reset (reset=1 at a clk edge)
//     - All entries and wr_cnt go to 0 at that edge.
//     - reset has priority over we; a write presented in the reset cycle is dropped.
//     - Reset mid-stream: writes committed before the reset edge are lost.
//     - rd1/rd2/dbg_d read 0 from the edge onward; write-through still applies during reset if BYPASS=1.
//   Write
//     - Commits on an edge where reset=0 and we=1 and wa!=0: entry[wa] <= wd; wr_cnt <= wr_cnt+1.
//     - Latency: 1 cycle for registered readers.
//     - wa==0 with we=1: no state change, wr_cnt unchanged (write discarded).
//   Read
//     - Purely combinational, 0-cycle latency: rdN = (raN==0) ? 0 : entry[raN].
//     - Bypass (BYPASS=1): if we && wa!=0 && raN==wa, then rdN = wd.
//       Applies to each port independently.
//     - Both ports may address the same register; identical values result.
//   Width rules
//     - No extension or truncation; wd is stored bit-exact.
//     - Entry 0 always reads 0 on every port, including dbg_d; it is never stored or optimised to non-zero.
//   No state machine beyond the storage array and wr_cnt. No X may propagate to outputs after the first reset.
// TESTING
//   1. Reset 2 cycles, then read ra1=1..31, ra2=31..1 -> all rd1/rd2 = 0, wr_cnt = 0.
//   2. we=1 wa=8 wd=0xDEADBEEF, next cycle ra1=8 -> rd1 = 0xDEADBEEF, wr_cnt = 1.
//   3. we=1 wa=0 wd=0xFFFFFFFF, then ra1=0 ra2=0 -> rd1 = rd2 = 0, wr_cnt unchanged.
//   4. BYPASS=1: entry9=0x11, same cycle we=1 wa=9 wd=0x22 ra1=9 ra2=9 -> rd1 = rd2 = 0x22, dbg_a=9 gives 0x11.
//      BYPASS=0 -> rd1 = rd2 = 0x11.
//   5. Write 0x5 to reg 31, then assert reset with we=1 wa=31 wd=0x7 -> reg 31 reads 0 after the edge, wr_cnt = 0.
//   6. 65537 writes wa=1 wd=i -> wr_cnt wraps to 1, rd for ra=1 returns 0x10000.

Source files
------------

// File: rtl/reg_file_if.sv
// reg_file_if: bus between the datapath and the register file.
//   we/wa/wd   write port (RegWrite, write-register mux, MemToReg mux)
//   ra1/ra2    read addresses (rs / rt); rd1/rd2 are the combinational read data
//   dbg_a      debug read address; dbg_d is the debug read data, never bypassed
//   wr_cnt     count of committed writes since reset
// The master modport is the datapath side. The slave modport is the register file side.
interface reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [ADDR_W-1:0] dbg_a;
    logic [WIDTH-1:0]  dbg_d;
    logic [15:0]       wr_cnt;

    modport master (
        output we, wa, wd, ra1, ra2, dbg_a,
        input  rd1, rd2, dbg_d, wr_cnt
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, dbg_a,
        output rd1, rd2, dbg_d, wr_cnt
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: MIPS general-purpose register file.
//   It has 2 combinational read ports, 1 synchronous write port and a debug read port.
//   Register 0 is hard-wired to zero.
//   When BYPASS=1, a read port that addresses the register being written returns wd in the same cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every entry and wr_cnt
//   bus    reg_file_if.slave (we/wa/wd, ra1/ra2 -> rd1/rd2, dbg_a -> dbg_d, wr_cnt)
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [15:0]      r_wr_cnt;

    logic             w_wr_valid;   // a write to a real register is presented this cycle
    logic             w_commit;     // that write actually lands at the next edge
    logic             w_byp1;
    logic             w_byp2;

    assign w_wr_valid = bus.we && (bus.wa != '0);
    assign w_commit   = w_wr_valid && !reset;

    // Bypass looks only at the presented write and ignores reset. A reader in the reset
    // cycle still sees wd, even though the write is dropped at the edge.
    assign w_byp1 = BYPASS && w_wr_valid && (bus.ra1 == bus.wa);
    assign w_byp2 = BYPASS && w_wr_valid && (bus.ra2 == bus.wa);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_cnt <= '0;
        end else if (w_commit) begin
            r_mem[bus.wa] <= bus.wd;
            r_wr_cnt      <= r_wr_cnt + 16'd1;
        end
    end

    // Address 0 is masked on the read side. This keeps entry 0 at zero on every port,
    // whatever the array holds.
    always_comb begin
        bus.rd1 = '0;
        if (w_byp1) begin
            bus.rd1 = bus.wd;
        end else if (bus.ra1 != '0) begin
            bus.rd1 = r_mem[bus.ra1];
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (w_byp2) begin
            bus.rd2 = bus.wd;
        end else if (bus.ra2 != '0) begin
            bus.rd2 = r_mem[bus.ra2];
        end
    end

    always_comb begin
        bus.dbg_d = '0;
        if (bus.dbg_a != '0) begin
            bus.dbg_d = r_mem[bus.dbg_a];
        end
    end

    assign bus.wr_cnt = r_wr_cnt;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, table-driven bench for reg_file.
// Two instances share the same stimulus: u_byp has BYPASS=1 and u_nob has BYPASS=0.
// Both hold identical storage, so they differ only in the read data of a same-cycle write.
module tb_reg_file;
    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_a;

    int total;
    int bad;

    reg_file_if #(.WIDTH(32), .ADDR_W(5)) b_byp ();
    reg_file_if #(.WIDTH(32), .ADDR_W(5)) b_nob ();

    assign b_byp.we = we;  assign b_byp.wa = wa;   assign b_byp.wd = wd;
    assign b_byp.ra1 = ra1; assign b_byp.ra2 = ra2; assign b_byp.dbg_a = dbg_a;
    assign b_nob.we = we;  assign b_nob.wa = wa;   assign b_nob.wd = wd;
    assign b_nob.ra1 = ra1; assign b_nob.ra2 = ra2; assign b_nob.dbg_a = dbg_a;

    reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (.clk(clk), .reset(reset), .bus(b_byp));
    reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (.clk(clk), .reset(reset), .bus(b_nob));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dbg_a;
        logic [31:0] e_rd1_b;   // rd1 expected with BYPASS=1
        logic [31:0] e_rd1_n;   // rd1 expected with BYPASS=0
        logic [31:0] e_rd2_b;
        logic [31:0] e_rd2_n;
        logic [31:0] e_dbg;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // The inputs are already driven. Compare at the falling edge, then take one rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_a = '0;

        // Test vectors: {we, wa, wd, ra1, ra2, dbg_a, rd1 bypass/no-bypass, rd2 bypass/no-bypass, dbg, cnt}.
        // Expected values are those seen before the edge of that cycle.
        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd0,  5'd8,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        16'd0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        16'd1};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd8,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        16'd1};
        vecs[4] = '{1'b1, 5'd9,  32'h11,       5'd1,  5'd2,  5'd9,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        16'd1};
        vecs[5] = '{1'b1, 5'd9,  32'h22,       5'd9,  5'd9,  5'd9,  32'h22,       32'h11,       32'h22,       32'h11,       32'h11,       16'd2};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd8,  5'd9,  32'h22,       32'h22,       32'hDEADBEEF, 32'hDEADBEEF, 32'h22,       16'd3};
        vecs[7] = '{1'b1, 5'd31, 32'hA5A50F0F, 5'd31, 5'd9,  5'd31, 32'hA5A50F0F, 32'h0,        32'h22,       32'h22,       32'h0,        16'd3};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31, 32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F, 32'hA5A50F0F, 16'd4};

        // Hold reset for 2 cycles, then sweep both read ports across the whole file.
        tick(); tick();
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(32 - i); dbg_a = 5'(i);
            @(negedge clk);
            chk($sformatf("rst_rd1[%0d]", i), b_byp.rd1, 32'h0);
            chk($sformatf("rst_rd2[%0d]", 32 - i), b_nob.rd2, 32'h0);
            chk($sformatf("rst_dbg[%0d]", i), b_byp.dbg_d, 32'h0);
            tick();
        end
        chk("rst_cnt", {16'h0, b_byp.wr_cnt}, 32'h0);

        for (int v = 0; v < 9; v++) begin
            we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
            ra1 = vecs[v].ra1; ra2 = vecs[v].ra2; dbg_a = vecs[v].dbg_a;
            @(negedge clk);
            chk($sformatf("v%0d rd1_byp", v), b_byp.rd1, vecs[v].e_rd1_b);
            chk($sformatf("v%0d rd1_nob", v), b_nob.rd1, vecs[v].e_rd1_n);
            chk($sformatf("v%0d rd2_byp", v), b_byp.rd2, vecs[v].e_rd2_b);
            chk($sformatf("v%0d rd2_nob", v), b_nob.rd2, vecs[v].e_rd2_n);
            chk($sformatf("v%0d dbg_byp", v), b_byp.dbg_d, vecs[v].e_dbg);
            chk($sformatf("v%0d dbg_nob", v), b_nob.dbg_d, vecs[v].e_dbg);
            chk($sformatf("v%0d cnt_byp", v), {16'h0, b_byp.wr_cnt}, {16'h0, vecs[v].e_cnt});
            chk($sformatf("v%0d cnt_nob", v), {16'h0, b_nob.wr_cnt}, {16'h0, vecs[v].e_cnt});
            tick();
        end

        // Write 0x5 to reg 31, then assert reset while a write of 0x7 is presented.
        // The reset must win: reg 31 reads 0 afterwards and the count returns to 0.
        we = 1'b1; wa = 5'd31; wd = 32'h5; ra1 = 5'd31; ra2 = 5'd0; dbg_a = 5'd31;
        tick();
        reset = 1'b1; wd = 32'h7;
        @(negedge clk);
        chk("rstwr rd1_byp", b_byp.rd1, 32'h7);
        chk("rstwr rd1_nob", b_nob.rd1, 32'h5);
        chk("rstwr cnt_pre", {16'h0, b_byp.wr_cnt}, 32'd5);
        tick();
        reset = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("rstwr rd1_byp_after", b_byp.rd1, 32'h0);
        chk("rstwr rd1_nob_after", b_nob.rd1, 32'h0);
        chk("rstwr dbg_after", b_byp.dbg_d, 32'h0);
        chk("rstwr cnt_after", {16'h0, b_nob.wr_cnt}, 32'h0);
        tick();

        // Make 65537 writes to reg 1 with wd=i. The counter wraps through 0xFFFF back to 1.
        we = 1'b1; wa = 5'd1; ra1 = 5'd1; ra2 = 5'd0; dbg_a = 5'd1;
        for (int i = 0; i < 65537; i++) begin
            wd = 32'(i);
            if (i == 65535) begin
                @(negedge clk);
                chk("wrap cnt_ffff", {16'h0, b_byp.wr_cnt}, 32'h0000FFFF);
                chk("wrap dbg_pre", b_byp.dbg_d, 32'h0000FFFE);
            end
            tick();
        end
        we = 1'b0;
        @(negedge clk);
        chk("wrap cnt", {16'h0, b_byp.wr_cnt}, 32'd1);
        chk("wrap cnt_nob", {16'h0, b_nob.wr_cnt}, 32'd1);
        chk("wrap rd1_byp", b_byp.rd1, 32'h00010000);
        chk("wrap rd1_nob", b_nob.rd1, 32'h00010000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
